fp32_adder_unit: RTL and testbench
==================================

Name: fp32_adder_unit

Overview:
- Sequential IEEE-754 single-precision floating-point adder/subtractor.
- Captures two 32-bit operands on a valid/done handshake, then classifies the operands for exceptions.
- Aligns exponents, adds or subtracts 24-bit significands with guard/round/sticky bits, normalizes, rounds, and returns the packed result with a 3-bit exception code.
- Sits as the FP add datapath behind a simple request/response caller interface.

Parameters:
- LATENCY, 5, clock edges from operand capture to Dataout_valid rising. Fixed; a documentation constant, not tunable.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RSTn  in  1  reset. Asynchronous, active-high despite the name.
- Datain1  in  32  operand A, IEEE-754 single.
- Datain2  in  32  operand B, IEEE-754 single.
- Data_valid  in  1  request. Caller holds it high until Dataout_valid is seen.
- Mode  in  3  000 = A+B; 001 = A−B (B sign inverted); other codes behave as 000.
- Debug  in  5  reserved; ignored.
- Dataout  out  32  packed result.
- Dataout_valid  out  1  result valid.
- Exc  out  3  result exception code.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While RSTn=1, FSM=IDLE, Dataout=0, Dataout_valid=0, Exc=000, internal registers cleared. Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE→UNPACK→ALIGN→ADD→NORM→ROUND→DONE.
- IDLE: when Data_valid=1 at a rising edge, Datain1/Datain2/Mode are captured and the FSM goes to UNPACK. Later input changes are ignored until the next capture.
- Latency: Dataout_valid rises at edge N+5, where N is the capture edge. Dataout and Exc are valid in the same cycle and stable while Dataout_valid=1.
- DONE: Dataout_valid stays 1 while Data_valid=1. The first edge with Data_valid=0 clears Dataout_valid and returns to IDLE. Dataout/Exc hold their last values until the next result. If Data_valid is already 0 on entering DONE, Dataout_valid is high for exactly one cycle.
- A new request is accepted only in IDLE, so Dataout_valid=0 is guaranteed before the next capture.
- UNPACK / exception classification: per operand, exp=0 with frac=0 is zero; exp=0 with frac≠0 is denormal and is flushed to signed zero; exp=255 with frac=0 is infinity; exp=255 with frac≠0 is NaN. Significand = {1, frac} (24 bits) for normal operands.
- ALIGN: swap so the larger-magnitude operand is first (compare exponent, then significand). Shift the smaller significand right by the exponent difference into a 27-bit {sig, G, R, S} field; S ORs all shifted-out bits. A difference ≥ 27 leaves only S.
- ADD: effective add if signs are equal, else subtract smaller from larger (always non-negative). Uses a 25-bit result with carry-out. Result sign = sign of the larger-magnitude operand.
- NORM: on carry-out, shift right 1 (into sticky) and exp+1. Otherwise shift left until MSB=1, decrementing exp. A zero significand gives exact zero.
- ROUND: round-to-nearest-even using G,R,S. A rounding carry renormalizes (exp+1).
- Overflow (exp ≥ 255) gives ±Inf, Exc=101. Underflow (exp ≤ 0) gives signed zero, Exc=110.
- Special cases:
  - Any NaN input gives 0x7FC00000, Exc=100.
  - Inf + opposite Inf gives 0x7FC00000, Exc=100.
  - Inf with a finite operand gives that Inf, Exc=011.
  - Exact cancellation gives +0 (0x00000000), Exc=001.
  - Zero + x gives x.
- Exc codes: 000 normal result, 001 zero, 011 infinity input, 100 NaN, 101 overflow, 110 underflow.

Test Plan:
- Reset, then A=0x40300000 (2.75), B=0x40B00000 (5.5), Mode=000 → Dataout=0x41040000 (8.25), Exc=000. Dataout_valid rises 5 edges after capture and drops after Data_valid falls.
- A=0xC0300000 (−2.75), B=0x40B00000 (5.5) → 0x40300000 (2.75). Swapped signs, A=0x40300000, B=0xC0B00000 → 0xC0300000 (−2.75).
- A=0x402013D3 (2.50121), B=0xC756D800 (−55000) → 0xC756D580 (−54997.5). Exercises sticky bits and round-to-nearest-even.
- A=0x42140000 (37), B=0xC2480000 (−50) → 0xC1500000 (−13). Exercises multi-bit left normalization.
- Special cases:
  - A=0x3F800000, B=0xBF800000 → 0x00000000, Exc=001.
  - A=0x7F7FFFFF, B=0x7F7FFFFF → 0x7F800000, Exc=101.
  - A=0x7F800000, B=0xFF800000 → 0x7FC00000, Exc=100.
- Assert RSTn two cycles into an operation → Dataout_valid never rises, outputs cleared. The next request completes normally.

Source files
------------

// File: rtl/fp32_adder_unit.sv
// Sequential IEEE-754 single-precision adder/subtractor: one datapath step per FSM state,
// round-to-nearest-even, packed result and exception code registered on entry to DONE.
module fp32_adder_unit (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [31:0] Datain1,
    input  logic [31:0] Datain2,
    input  logic        Data_valid,
    input  logic [2:0]  Mode,
    input  logic [4:0]  Debug,
    output logic [31:0] Dataout,
    output logic        Dataout_valid,
    output logic [2:0]  Exc
);

    localparam int LATENCY = 5;

    // ROUND sits LATENCY-1 steps after capture; its exit edge raises Dataout_valid.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADD    = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'(LATENCY),
        S_DONE   = 3'(LATENCY + 1)
    } state_t;

    localparam logic [31:0] QNAN_C = 32'h7FC0_0000;

    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        valid_nxt_s, load_s, capture_s;

    logic [31:0] a_r, b_r;
    logic [2:0]  mode_r;
    logic        sa_r, sb_r;
    logic [7:0]  ea_r, eb_r;
    logic [23:0] ma_r, mb_r;
    logic        spec_r;
    logic [31:0] spec_val_r;
    logic [2:0]  spec_exc_r;
    logic [26:0] big_r, small_r;
    logic        sign_r, sub_r;
    logic [9:0]  exp_r;
    logic [27:0] sum_r;
    logic [26:0] norm_r;
    logic        zero_r;

    logic        unused_debug_s;
    assign unused_debug_s = ^Debug;

    // State register.
    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn) state_r <= S_IDLE;
        else      state_r <= state_nxt_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (Data_valid) state_nxt_s = S_UNPACK;
                else            state_nxt_s = S_IDLE;
            end
            S_UNPACK: state_nxt_s = S_ALIGN;
            S_ALIGN:  state_nxt_s = S_ADD;
            S_ADD:    state_nxt_s = S_NORM;
            S_NORM:   state_nxt_s = S_ROUND;
            S_ROUND:  state_nxt_s = S_DONE;
            S_DONE: begin
                if (Data_valid) state_nxt_s = S_DONE;
                else            state_nxt_s = S_IDLE;
            end
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode, registered below.
    always_comb begin
        valid_nxt_s = (state_nxt_s == S_DONE);
        load_s      = (state_r == S_ROUND);
        capture_s   = (state_r == S_IDLE) && Data_valid;
    end

    // Unpack: classify operands, flush denormals, resolve NaN/Inf/both-zero up front.
    logic        ua_sign_s, ub_sign_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic        u_spec_s;
    logic [31:0] u_spec_val_s;
    logic [2:0]  u_spec_exc_s;
    always_comb begin
        ua_sign_s = a_r[31];
        ub_sign_s = b_r[31] ^ (mode_r == 3'b001);
        a_zero_s  = (a_r[30:23] == 8'd0);
        b_zero_s  = (b_r[30:23] == 8'd0);
        a_inf_s   = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
        b_inf_s   = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
        a_nan_s   = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
        b_nan_s   = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);
        u_spec_s     = 1'b1;
        u_spec_val_s = 32'd0;
        u_spec_exc_s = 3'b000;
        if (a_nan_s || b_nan_s) begin
            u_spec_val_s = QNAN_C;
            u_spec_exc_s = 3'b100;
        end else if (a_inf_s && b_inf_s) begin
            if (ua_sign_s != ub_sign_s) begin
                u_spec_val_s = QNAN_C;
                u_spec_exc_s = 3'b100;
            end else begin
                u_spec_val_s = {ua_sign_s, 8'hFF, 23'd0};
                u_spec_exc_s = 3'b011;
            end
        end else if (a_inf_s) begin
            u_spec_val_s = {ua_sign_s, 8'hFF, 23'd0};
            u_spec_exc_s = 3'b011;
        end else if (b_inf_s) begin
            u_spec_val_s = {ub_sign_s, 8'hFF, 23'd0};
            u_spec_exc_s = 3'b011;
        end else if (a_zero_s && b_zero_s) begin
            u_spec_val_s = {ua_sign_s & ub_sign_s, 31'd0};
            u_spec_exc_s = 3'b001;
        end else begin
            u_spec_s = 1'b0;
        end
    end

    // Align: larger magnitude first, smaller significand shifted into {sig,G,R,S}.
    logic        a_ge_b_s, sl_s, ss_s;
    logic [7:0]  el_s, es_s, diff_s;
    logic [23:0] ml_s, ms_s;
    logic [26:0] small_full_s, small_al_s, lost_mask_s;
    always_comb begin
        a_ge_b_s = ({ea_r, ma_r} >= {eb_r, mb_r});
        if (a_ge_b_s) begin
            sl_s = sa_r; el_s = ea_r; ml_s = ma_r;
            ss_s = sb_r; es_s = eb_r; ms_s = mb_r;
        end else begin
            sl_s = sb_r; el_s = eb_r; ml_s = mb_r;
            ss_s = sa_r; es_s = ea_r; ms_s = ma_r;
        end
        diff_s       = el_s - es_s;
        small_full_s = {ms_s, 3'b000};
        lost_mask_s  = ~({27{1'b1}} << diff_s);
        if (diff_s >= 8'd27) begin
            small_al_s = {26'd0, |ms_s};
        end else begin
            small_al_s    = small_full_s >> diff_s;
            small_al_s[0] = small_al_s[0] | (|(small_full_s & lost_mask_s));
        end
    end

    // Add/subtract with carry-out; subtraction is always larger minus smaller.
    logic [27:0] sum_s;
    always_comb begin
        if (sub_r) sum_s = {1'b0, big_r} - {1'b0, small_r};
        else       sum_s = {1'b0, big_r} + {1'b0, small_r};
    end

    // Normalize: carry shifts right into sticky, otherwise left by leading-zero count.
    logic [4:0]  lz_s;
    logic [26:0] norm_s;
    logic [9:0]  nexp_s;
    logic        nzero_s;
    always_comb begin
        lz_s    = clz27(sum_r[26:0]);
        nzero_s = 1'b0;
        if (sum_r[27]) begin
            norm_s = {sum_r[27:2], sum_r[1] | sum_r[0]};
            nexp_s = exp_r + 10'd1;
        end else if (sum_r == 28'd0) begin
            norm_s  = 27'd0;
            nexp_s  = exp_r;
            nzero_s = 1'b1;
        end else begin
            norm_s = sum_r[26:0] << lz_s;
            nexp_s = exp_r - {5'd0, lz_s};
        end
    end

    // Round to nearest even and pack; exp_r is two's complement so underflow shows as sign.
    logic        round_up_s;
    logic [24:0] mant_rnd_s;
    logic [22:0] frac_s;
    logic [9:0]  exp_fin_s;
    logic [31:0] res_s;
    logic [2:0]  res_exc_s;
    always_comb begin
        round_up_s = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
        mant_rnd_s = {1'b0, norm_r[26:3]} + {24'd0, round_up_s};
        if (mant_rnd_s[24]) begin
            frac_s    = mant_rnd_s[23:1];
            exp_fin_s = exp_r + 10'd1;
        end else begin
            frac_s    = mant_rnd_s[22:0];
            exp_fin_s = exp_r;
        end
        if (spec_r) begin
            res_s     = spec_val_r;
            res_exc_s = spec_exc_r;
        end else if (zero_r) begin
            res_s     = 32'd0;
            res_exc_s = 3'b001;
        end else if (!exp_fin_s[9] && (exp_fin_s >= 10'd255)) begin
            res_s     = {sign_r, 8'hFF, 23'd0};
            res_exc_s = 3'b101;
        end else if (exp_fin_s[9] || (exp_fin_s == 10'd0)) begin
            res_s     = {sign_r, 31'd0};
            res_exc_s = 3'b110;
        end else begin
            res_s     = {sign_r, exp_fin_s[7:0], frac_s};
            res_exc_s = 3'b000;
        end
    end

    // Datapath registers, one stage written per state.
    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn) begin
            a_r <= 32'd0; b_r <= 32'd0; mode_r <= 3'd0;
            sa_r <= 1'b0; sb_r <= 1'b0; ea_r <= 8'd0; eb_r <= 8'd0;
            ma_r <= 24'd0; mb_r <= 24'd0;
            spec_r <= 1'b0; spec_val_r <= 32'd0; spec_exc_r <= 3'd0;
            big_r <= 27'd0; small_r <= 27'd0; sign_r <= 1'b0; sub_r <= 1'b0;
            exp_r <= 10'd0; sum_r <= 28'd0; norm_r <= 27'd0; zero_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (capture_s) begin
                        a_r    <= Datain1;
                        b_r    <= Datain2;
                        mode_r <= Mode;
                    end
                end
                S_UNPACK: begin
                    sa_r       <= ua_sign_s;
                    sb_r       <= ub_sign_s;
                    ea_r       <= a_zero_s ? 8'd0 : a_r[30:23];
                    eb_r       <= b_zero_s ? 8'd0 : b_r[30:23];
                    ma_r       <= a_zero_s ? 24'd0 : {1'b1, a_r[22:0]};
                    mb_r       <= b_zero_s ? 24'd0 : {1'b1, b_r[22:0]};
                    spec_r     <= u_spec_s;
                    spec_val_r <= u_spec_val_s;
                    spec_exc_r <= u_spec_exc_s;
                end
                S_ALIGN: begin
                    big_r   <= {ml_s, 3'b000};
                    small_r <= small_al_s;
                    sign_r  <= sl_s;
                    sub_r   <= sl_s ^ ss_s;
                    exp_r   <= {2'b00, el_s};
                end
                S_ADD: sum_r <= sum_s;
                S_NORM: begin
                    norm_r <= norm_s;
                    exp_r  <= nexp_s;
                    zero_r <= nzero_s;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs; result and code hold until the next ROUND.
    always_ff @(posedge CLK or posedge RSTn) begin
        if (RSTn) begin
            Dataout       <= 32'd0;
            Exc           <= 3'b000;
            Dataout_valid <= 1'b0;
        end else begin
            Dataout_valid <= valid_nxt_s;
            if (load_s) begin
                Dataout <= res_s;
                Exc     <= res_exc_s;
            end else begin
                Dataout <= Dataout;
                Exc     <= Exc;
            end
        end
    end

endmodule

// File: tb/tb_fp32_adder_unit.sv
// Directed-vector bench for fp32_adder_unit: latency, handshake, rounding and special cases.
module tb_fp32_adder_unit;

    logic        CLK;
    logic        RSTn;
    logic [31:0] Datain1, Datain2;
    logic        Data_valid;
    logic [2:0]  Mode;
    logic [4:0]  Debug;
    logic [31:0] Dataout;
    logic        Dataout_valid;
    logic [2:0]  Exc;

    int total_cnt;
    int bad_cnt;

    fp32_adder_unit dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .Datain1       (Datain1),
        .Datain2       (Datain2),
        .Data_valid    (Data_valid),
        .Mode          (Mode),
        .Debug         (Debug),
        .Dataout       (Dataout),
        .Dataout_valid (Dataout_valid),
        .Exc           (Exc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total_cnt++;
        if (got !== expv) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, expv);
        end
    endtask

    // One full request: capture, latency, hold while Data_valid high, release.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] md, input logic [31:0] exp_d, input logic [2:0] exp_x);
        int n;
        @(negedge CLK);
        Datain1 = a; Datain2 = b; Mode = md; Data_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Datain1 = ~a; Datain2 = 32'h3F80_0000; Mode = 3'b001;
        n = 0;
        while (!Dataout_valid && n < 20) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
        end
        chk({tag, ".lat"}, 32'(n), 32'd5);
        chk({tag, ".data"}, Dataout, exp_d);
        chk({tag, ".exc"}, {29'd0, Exc}, {29'd0, exp_x});
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, ".hold"}, {31'd0, Dataout_valid}, 32'd1);
        Data_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk({tag, ".drop"}, {31'd0, Dataout_valid}, 32'd0);
        chk({tag, ".keep"}, Dataout, exp_d);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        RSTn = 1'b1; Data_valid = 1'b0; Datain1 = 32'd0; Datain2 = 32'd0;
        Mode = 3'b000; Debug = 5'b10101;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst.data", Dataout, 32'd0);
        chk("rst.valid", {31'd0, Dataout_valid}, 32'd0);
        chk("rst.exc", {29'd0, Exc}, 32'd0);
        RSTn = 1'b0;

        run_op("add",     32'h4030_0000, 32'h40B0_0000, 3'b000, 32'h4104_0000, 3'b000);
        run_op("negA",    32'hC030_0000, 32'h40B0_0000, 3'b000, 32'h4030_0000, 3'b000);
        run_op("negB",    32'h4030_0000, 32'hC0B0_0000, 3'b000, 32'hC030_0000, 3'b000);
        run_op("sticky",  32'h4020_13D3, 32'hC756_D800, 3'b000, 32'hC756_D580, 3'b000);
        run_op("lnorm",   32'h4214_0000, 32'hC248_0000, 3'b000, 32'hC150_0000, 3'b000);
        run_op("sub",     32'h4030_0000, 32'h40B0_0000, 3'b001, 32'hC030_0000, 3'b000);
        run_op("mode2",   32'h4030_0000, 32'h40B0_0000, 3'b010, 32'h4104_0000, 3'b000);
        run_op("cancel",  32'h3F80_0000, 32'hBF80_0000, 3'b000, 32'h0000_0000, 3'b001);
        run_op("ovf",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b000, 32'h7F80_0000, 3'b101);
        run_op("infinf",  32'h7F80_0000, 32'hFF80_0000, 3'b000, 32'h7FC0_0000, 3'b100);
        run_op("nan",     32'h7FC0_0001, 32'h3F80_0000, 3'b000, 32'h7FC0_0000, 3'b100);
        run_op("inffin",  32'h3F80_0000, 32'hFF80_0000, 3'b000, 32'hFF80_0000, 3'b011);
        run_op("zero",    32'h0000_0000, 32'h40B0_0000, 3'b000, 32'h40B0_0000, 3'b000);
        run_op("denorm",  32'h0000_0001, 32'h3F80_0000, 3'b000, 32'h3F80_0000, 3'b000);
        run_op("tieeven", 32'h3F80_0000, 32'h3380_0000, 3'b000, 32'h3F80_0000, 3'b000);
        run_op("tieodd",  32'h3F80_0001, 32'h3380_0000, 3'b000, 32'h3F80_0002, 3'b000);
        run_op("unf",     32'h0080_0001, 32'h8080_0000, 3'b000, 32'h0000_0000, 3'b110);

        // Single-cycle valid when the request drops before the result.
        @(negedge CLK);
        Datain1 = 32'h4030_0000; Datain2 = 32'h40B0_0000; Mode = 3'b000; Data_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Data_valid = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("pulse.pre", {31'd0, Dataout_valid}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        chk("pulse.on", {31'd0, Dataout_valid}, 32'd1);
        chk("pulse.data", Dataout, 32'h4104_0000);
        @(posedge CLK);
        @(negedge CLK);
        chk("pulse.off", {31'd0, Dataout_valid}, 32'd0);

        // Reset two cycles into an operation aborts it.
        @(negedge CLK);
        Datain1 = 32'h4214_0000; Datain2 = 32'hC248_0000; Mode = 3'b000; Data_valid = 1'b1;
        @(posedge CLK);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Data_valid = 1'b0;
        RSTn = 1'b1;
        #1;
        chk("abort.data", Dataout, 32'd0);
        chk("abort.valid", {31'd0, Dataout_valid}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (8) begin
                @(negedge CLK);
                if (Dataout_valid) seen++;
            end
            chk("abort.never", 32'(seen), 32'd0);
        end
        run_op("after", 32'h4214_0000, 32'hC248_0000, 3'b000, 32'hC150_0000, 3'b000);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
